// File: rtl/mem_1w1r_pkg.sv
// rtl/mem_1w1r_pkg.sv - collision-mode constants for mem_1w1r
package mem_1w1r_pkg;

  localparam int BYPASS_OLD = 0;  // same-address read returns the pre-write word
  localparam int BYPASS_NEW = 1;  // same-address read returns the word being written

endpackage

// File: rtl/mem_1w1r.sv
// rtl/mem_1w1r.sv - simple dual-port RAM, one write port, one registered read port
module mem_1w1r
  import mem_1w1r_pkg::*;
#(
  parameter int ELEMENTS_W = 4,
  parameter int WIDTH      = 8,
  parameter int BYPASS     = BYPASS_OLD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read,
  input  logic [ELEMENTS_W-1:0] readaddress,
  output logic [WIDTH-1:0]      readdata,
  input  logic                  write,
  input  logic [ELEMENTS_W-1:0] writeaddress,
  input  logic [WIDTH-1:0]      writedata
);

  localparam int DEPTH = 1 << ELEMENTS_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] readdata_q;
  logic [WIDTH-1:0] readdata_d;
  logic             collide;

  // Array has no reset; writes are only blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && write) begin
      mem_q[writeaddress] <= writedata;
    end
  end

  assign collide = write && (writeaddress == readaddress);

  always_comb begin
    readdata_d = readdata_q;
    if (read) begin
      if ((BYPASS == BYPASS_NEW) && collide) begin
        readdata_d = writedata;
      end else begin
        readdata_d = mem_q[readaddress];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

`ifdef MEM_1W1R_DEBUG
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      assert (!$isunknown({read, write})) else $error("mem_1w1r: X/Z on read/write");
      assert (!(read && $isunknown(readaddress))) else $error("mem_1w1r: X on readaddress");
      assert (!(write && $isunknown(writeaddress))) else $error("mem_1w1r: X on writeaddress");
    end else if (rst_n !== 1'b0) begin
      assert (0) else $error("mem_1w1r: X/Z on rst_n");
    end
  end
`endif

endmodule

// File: tb/tb_mem_1w1r.sv
// tb/tb_mem_1w1r.sv - scoreboard bench for three mem_1w1r configurations
module tb_mem_1w1r;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd [3];
  logic [5:0]  ra [3];
  logic        wr [3];
  logic [5:0]  wa [3];
  logic [31:0] wd [3];
  logic [7:0]  q0;
  logic [7:0]  q1;
  logic [21:0] q2;

  logic [31:0] model [3][64];
  logic [31:0] exp_q [3][$];
  logic [31:0] last  [3];
  int checks = 0;
  int passed = 0;
  string phase = "reset";

  always #5 clk = ~clk;

  mem_1w1r #(.ELEMENTS_W(4), .WIDTH(8), .BYPASS(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .read(rd[0]), .readaddress(ra[0][3:0]), .readdata(q0),
    .write(wr[0]), .writeaddress(wa[0][3:0]), .writedata(wd[0][7:0])
  );

  mem_1w1r #(.ELEMENTS_W(4), .WIDTH(8), .BYPASS(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .read(rd[1]), .readaddress(ra[1][3:0]), .readdata(q1),
    .write(wr[1]), .writeaddress(wa[1][3:0]), .writedata(wd[1][7:0])
  );

  mem_1w1r #(.ELEMENTS_W(6), .WIDTH(22), .BYPASS(0)) u2 (
    .clk(clk), .rst_n(rst_n),
    .read(rd[2]), .readaddress(ra[2]), .readdata(q2),
    .write(wr[2]), .writeaddress(wa[2]), .writedata(wd[2][21:0])
  );

  function automatic logic [31:0] dmask(int k);
    return (k < 2) ? 32'h0000_00FF : 32'h003F_FFFF;
  endfunction

  function automatic logic [5:0] amask(int k);
    return (k < 2) ? 6'h0F : 6'h3F;
  endfunction

  function automatic logic [31:0] getq(int k);
    case (k)
      0:       return {24'b0, q0};
      1:       return {24'b0, q1};
      default: return {10'b0, q2};
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; ra[k] = '0; wr[k] = 1'b0; wa[k] = '0; wd[k] = '0;
    end
  endtask

  // Drive one DUT for the coming edge and record what the read must return.
  task automatic issue(int k, logic r, logic [5:0] raddr, logic w, logic [5:0] waddr,
                       logic [31:0] data);
    logic [31:0] e;
    rd[k] = r; ra[k] = raddr & amask(k);
    wr[k] = w; wa[k] = waddr & amask(k); wd[k] = data & dmask(k);
    if (r) begin
      if (w && (wa[k] == ra[k]) && (k == 1)) e = wd[k];
      else e = model[k][ra[k]];
      exp_q[k].push_back(e);
    end
    if (w) model[k][wa[k]] = wd[k];
  endtask

  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (exp_q[k].size() > 0) begin
        e = exp_q[k].pop_front();
        check($sformatf("%s_read_u%0d", phase, k), getq(k), e);
        last[k] = e;
      end else begin
        check($sformatf("%s_hold_u%0d", phase, k), getq(k), last[k]);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    for (int k = 0; k < 3; k++) last[k] = '0;
    #3 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) issue(k, 1'b0, 6'd0, 1'b1, 6'd3, 32'h11);
    tick();
    for (int k = 0; k < 3; k++) issue(k, 1'b1, 6'd3, 1'b0, 6'd0, 32'h0);
    tick();

    phase = "async_reset";
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_u%0d", phase, k), getq(k), 32'h0);
      last[k] = '0;
    end
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 3; k++) begin
        rd[k] = 1'b1; ra[k] = 6'd3; wr[k] = 1'b1; wa[k] = 6'd3; wd[k] = 32'hAA;
      end
      tick();
    end
    rst_n = 1'b1;
    phase = "post_reset";
    for (int k = 0; k < 3; k++) issue(k, 1'b1, 6'd3, 1'b0, 6'd0, 32'h0);
    tick();

    phase = "basic";
    for (int k = 0; k < 3; k++) issue(k, 1'b0, 6'd0, 1'b1, 6'd2, 32'hA5);
    tick();
    for (int k = 0; k < 3; k++) issue(k, 1'b1, 6'd2, 1'b0, 6'd0, 32'h0);
    tick();

    phase = "hold";
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < 3; k++) issue(k, 1'b0, 6'd0, 1'b1, 6'd2, 32'h3C);
      tick();
    end
    for (int k = 0; k < 3; k++) issue(k, 1'b1, 6'd2, 1'b0, 6'd0, 32'h0);
    tick();

    phase = "collision";
    for (int k = 0; k < 3; k++) issue(k, 1'b0, 6'd0, 1'b1, 6'd5, 32'h10);
    tick();
    for (int k = 0; k < 3; k++) issue(k, 1'b1, 6'd5, 1'b1, 6'd5, 32'h20);
    tick();
    for (int k = 0; k < 3; k++) issue(k, 1'b1, 6'd5, 1'b0, 6'd0, 32'h0);
    tick();

    phase = "sweep";
    for (int a = 0; a < 64; a++) begin
      for (int k = 0; k < 3; k++)
        if (k == 2 || a < 16)
          issue(k, 1'b0, 6'd0, 1'b1, 6'(a), (k == 2) ? (32'(a) ^ 32'h15A5A) : (32'(a) ^ 32'h5A));
      tick();
    end
    for (int a = 0; a < 64; a++) begin
      for (int k = 0; k < 3; k++)
        if (k == 2 || a < 16) issue(k, 1'b1, 6'(a), 1'b0, 6'd0, 32'h0);
      tick();
    end

    phase = "concurrent";
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 3; k++)
        issue(k, 1'b1, 6'(i - 1), 1'b1, 6'(i), 32'(i * 7 + 3) | (32'(i) << 12));
      tick();
    end
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_1w1r.md
Name: mem_1w1r

Overview:
- Simple dual-port synchronous RAM: one write port and one registered read port, single clock.
- Used as the storage primitive in TLB ways for the physical-tag, virtual-tag and access-tag arrays, and available for other small caches.
- Read data appears one cycle after a read request and holds until the next read request.
- No reset of the array contents; only the output register is reset.

Parameters:
- ELEMENTS_W, 4, address width; depth = 2**ELEMENTS_W entries.
- WIDTH, 8, data width in bits per entry.
- BYPASS, 0, read/write collision mode (0 = read returns old data, 1 = read returns new write data).

Ports:
- clk  in  1  clock; all sampling on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- read  in  1  read request; sampled on the rising clk edge.
- readaddress  in  ELEMENTS_W  entry to read.
- readdata  out  WIDTH  registered read result.
- write  in  1  write request; sampled on the rising clk edge.
- writeaddress  in  ELEMENTS_W  entry to write.
- writedata  in  WIDTH  data to store.

Behaviour:
- Storage: array of 2**ELEMENTS_W words of WIDTH bits.
  - Contents are not reset and are undefined (X in simulation) until written.
  - Users must write an entry before relying on its read value.
- Reset:
  - rst_n low forces readdata to 0 immediately, asynchronously.
  - While rst_n is low, read and write are ignored and the array is unchanged.
  - Deassertion is sampled at a clk edge; the first edge with rst_n high may perform a read or write.
- Write: at posedge clk with rst_n high and write=1, mem[writeaddress] <= writedata. write=0 leaves the array unchanged.
- Read:
  - At posedge clk with rst_n high and read=1, readdata <= mem[readaddress]. Latency is exactly 1 cycle.
  - read=0 holds readdata at its previous value indefinitely. Callers depend on this hold.
- Simultaneous read and write to different addresses: both complete in the same cycle, independently.
- Simultaneous read and write to the same address:
  - BYPASS=0: readdata gets the value stored before the write; the array gets writedata.
  - BYPASS=1: readdata gets writedata.
- Back-to-back: a write at edge N followed by a read of the same address at edge N+1 returns the new data after edge N+1, in both modes.
- Addresses are full-range; there is no out-of-range case and no wrap-around logic.
- Read and write issued on every cycle are supported; there is no handshake and no stall.
- Simulation-only checks, under a debug define:
  - Flag X/Z on read, write or rst_n after reset.
  - Flag X on readaddress when read=1.
  - Flag X on writeaddress when write=1.

Decomposition:
- No shared package is needed; the module is fully parameterized.
- No sub-module is needed. It is one flat module: array, write process, and registered read with optional bypass mux.
- Collision-mode constants (0/1 for BYPASS) may live in the common defines include used by the cache/TLB blocks.

Test Plan:
- Reset: hold rst_n=0 with read=1 and write=1 to addr 3 (data 0xAA) -> readdata=0 throughout; afterwards addr 3 was not written (write 0x11 first, reset, read back 0x11).
- Basic write/read (ELEMENTS_W=4, WIDTH=8): write 0xA5 to addr 2, then read addr 2 -> readdata=0xA5 exactly one cycle after the read edge.
- Hold: after reading 0xA5, drive read=0 for 5 cycles while writing 0x3C to addr 2 -> readdata stays 0xA5; the next read of addr 2 gives 0x3C.
- Collision: mem[5]=0x10; same-edge read and write of addr 5 with data 0x20 -> BYPASS=0 gives readdata=0x10 then a re-read gives 0x20; BYPASS=1 gives readdata=0x20.
- Full sweep: write addr^0x5A to all 16 addresses, then read them back-to-back every cycle -> each readdata matches one cycle later. Repeat with WIDTH=22 and ELEMENTS_W=6.
- Concurrent distinct ports: each cycle write addr i while reading addr i-1 -> reads return the values written in earlier cycles, with no interference.
